uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage. It deserialises the 11-bit frame produced by the board's UART transmitter: a start bit (0), 8 data bits LSB first, a parity bit and a stop bit (1). It presents each received byte with a one-cycle valid strobe and error flags to downstream logic (display or register stage). It sits at the far end of the TX line and runs on the same 50 MHz clock with the same bit period.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rx_bit_timer.sv | 33 +++
 rtl/uart_receiver.sv | 147 ++++++++++++++
 tb/tb_uart_receiver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// The frame is: start(0), 8 data bits LSB first, parity, stop(1).
package uart_pkg;

   localparam int DATA_BITS         = 8;
   localparam int FRAME_BITS        = 11;
   localparam int CLKS_PER_BIT_9600 = 5208;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   // Expected parity bit: total ones over data plus parity is odd.
   function automatic logic parity_bit(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period cycle counter for the UART receiver.
// Flags the mid-bit point (half_tick) and the end of a full bit period (full_tick).
module rx_bit_timer #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic half_tick,
   output logic full_tick
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_r;

   // Free-running within a state; wraps at the end of each bit period.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
      end else if (restart || full_tick) begin
         cnt_r <= '0;
      end else begin
         cnt_r <= cnt_r + CW'(1);
      end
   end

   assign half_tick = (cnt_r == HALF_LAST);
   assign full_tick = (cnt_r == FULL_LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 2-flop synchroniser, mid-bit sampling FSM, byte output
// with a one-cycle valid strobe and held parity/framing flags.
module uart_receiver #(
   parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_9600,
   parameter int DATA_BITS    = 8
) (
   input  logic                 CLOCK_50,
   input  logic                 rst,
   input  logic                 RX,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 busy
);

   import uart_pkg::*;

   localparam int BW = $clog2(DATA_BITS);

   rx_state_t            state_r;
   logic [1:0]           sync_r;
   logic                 rx_s;
   logic [BW-1:0]        bit_cnt_r;
   logic [DATA_BITS-1:0] shift_r;
   logic                 parity_r;
   logic                 stop_r;
   logic                 pending_r;
   logic                 restart_s;
   logic                 half_tick_s;
   logic                 full_tick_s;

   // Two-stage synchroniser for the asynchronous RX line; idles high.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         sync_r <= 2'b11;
      end else begin
         sync_r <= {sync_r[0], RX};
      end
   end

   assign rx_s = sync_r[1];

   // The counter is held clear in IDLE so START begins at zero, and is cleared
   // again at mid start bit so data samples land mid-bit. Other state entries
   // coincide with a full_tick wrap.
   assign restart_s = (state_r == IDLE) || ((state_r == START) && half_tick_s);

   rx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_timer (
      .clk       (CLOCK_50),
      .rst       (rst),
      .restart   (restart_s),
      .half_tick (half_tick_s),
      .full_tick (full_tick_s)
   );

   // Receive FSM with registered outputs.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_r    <= IDLE;
         bit_cnt_r  <= '0;
         shift_r    <= '0;
         parity_r   <= 1'b0;
         stop_r     <= 1'b0;
         pending_r  <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!rx_s) begin
                  state_r <= START;
                  busy    <= 1'b1;
               end else begin
                  busy    <= 1'b0;
               end
            end
            START: begin
               if (half_tick_s) begin
                  if (!rx_s) begin
                     state_r   <= DATA;
                     bit_cnt_r <= '0;
                  end else begin
                     // Too short to be a start bit: drop it silently.
                     state_r <= IDLE;
                     busy    <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (full_tick_s) begin
                  shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
                  if (bit_cnt_r == BW'(DATA_BITS - 1)) begin
                     state_r   <= PARITY;
                     bit_cnt_r <= '0;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + BW'(1);
                  end
               end
            end
            PARITY: begin
               if (full_tick_s) begin
                  parity_r <= rx_s;
                  state_r  <= STOP;
               end
            end
            STOP: begin
               if (pending_r) begin
                  pending_r  <= 1'b0;
                  rx_data    <= shift_r;
                  parity_err <= (parity_r != parity_bit(shift_r));
                  frame_err  <= ~stop_r;
                  rx_valid   <= 1'b1;
                  if (stop_r) begin
                     state_r <= IDLE;
                     busy    <= 1'b0;
                  end else begin
                     state_r <= BREAK;
                  end
               end else if (full_tick_s) begin
                  stop_r    <= rx_s;
                  pending_r <= 1'b1;
               end
            end
            BREAK: begin
               // A held-low line reports one framing error, not a stream of frames.
               if (rx_s) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_r   <= IDLE;
               pending_r <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

   localparam int CPB = 16;

   logic       CLOCK_50 = 1'b0;
   logic       rst      = 1'b1;
   logic       RX       = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   int errors = 0;
   int checks = 0;

   int         valid_cnt  = 0;
   int         double_cnt = 0;
   logic       prev_valid = 1'b0;
   logic       busy_seen  = 1'b0;
   logic [7:0] data_log [0:15];
   logic       perr_log [0:15];
   logic       ferr_log [0:15];

   uart_receiver #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .CLOCK_50   (CLOCK_50),
      .rst        (rst),
      .RX         (RX),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   // Record every strobe and its flags, and any strobe longer than one cycle.
   always @(negedge CLOCK_50) begin
      if (rx_valid) begin
         if (valid_cnt < 16) begin
            data_log[valid_cnt] = rx_data;
            perr_log[valid_cnt] = parity_err;
            ferr_log[valid_cnt] = frame_err;
         end
         valid_cnt = valid_cnt + 1;
         if (prev_valid) double_cnt = double_cnt + 1;
      end
      prev_valid = rx_valid;
      if (busy) busy_seen = 1'b1;
   end

   task automatic bit_time(input logic v);
      RX = v;
      repeat (CPB) @(negedge CLOCK_50);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(d[i]);
      bit_time(p);
      bit_time(s);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      RX  = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b expected 0", parity_err); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      rst = 1'b0;
      repeat (4) @(negedge CLOCK_50);
   endtask

   task automatic test_good_frame();
      int base = valid_cnt;
      int dc   = double_cnt;
      send_frame(8'hA5, 1'b1, 1'b1);
      bit_time(1'b1); bit_time(1'b1);
      checks++; if (valid_cnt - base !== 1) begin errors++; $display("FAIL good_count: got %0d expected 1", valid_cnt - base); end
      checks++; if (data_log[base] !== 8'hA5) begin errors++; $display("FAIL good_data: got %h expected a5", data_log[base]); end
      checks++; if (perr_log[base] !== 1'b0) begin errors++; $display("FAIL good_perr: got %b expected 0", perr_log[base]); end
      checks++; if (ferr_log[base] !== 1'b0) begin errors++; $display("FAIL good_ferr: got %b expected 0", ferr_log[base]); end
      checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL good_hold: got %h expected a5", rx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy: got %b expected 0", busy); end
      checks++; if (double_cnt !== dc) begin errors++; $display("FAIL good_width: got %0d long strobes expected 0", double_cnt - dc); end
   endtask

   task automatic test_parity_error();
      int base = valid_cnt;
      send_frame(8'h07, 1'b1, 1'b1);
      bit_time(1'b1); bit_time(1'b1);
      checks++; if (valid_cnt - base !== 1) begin errors++; $display("FAIL perr_count: got %0d expected 1", valid_cnt - base); end
      checks++; if (data_log[base] !== 8'h07) begin errors++; $display("FAIL perr_data: got %h expected 07", data_log[base]); end
      checks++; if (perr_log[base] !== 1'b1) begin errors++; $display("FAIL perr_flag: got %b expected 1", perr_log[base]); end
      checks++; if (ferr_log[base] !== 1'b0) begin errors++; $display("FAIL perr_ferr: got %b expected 0", ferr_log[base]); end
   endtask

   task automatic test_glitch();
      int base = valid_cnt;
      busy_seen = 1'b0;
      RX = 1'b0;
      repeat (4) @(negedge CLOCK_50);
      bit_time(1'b1); bit_time(1'b1);
      checks++; if (busy_seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b expected 1", busy_seen); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy); end
      checks++; if (valid_cnt - base !== 0) begin errors++; $display("FAIL glitch_count: got %0d expected 0", valid_cnt - base); end
      checks++; if (rx_data !== 8'h07) begin errors++; $display("FAIL glitch_data_held: got %h expected 07", rx_data); end
      checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL glitch_perr_held: got %b expected 1", parity_err); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr_held: got %b expected 0", frame_err); end
   endtask

   task automatic test_break();
      int base = valid_cnt;
      send_frame(8'h3C, 1'b1, 1'b0);
      repeat (20 * CPB) @(negedge CLOCK_50);
      checks++; if (valid_cnt - base !== 1) begin errors++; $display("FAIL break_count: got %0d expected 1", valid_cnt - base); end
      checks++; if (data_log[base] !== 8'h3C) begin errors++; $display("FAIL break_data: got %h expected 3c", data_log[base]); end
      checks++; if (ferr_log[base] !== 1'b1) begin errors++; $display("FAIL break_ferr: got %b expected 1", ferr_log[base]); end
      checks++; if (perr_log[base] !== 1'b0) begin errors++; $display("FAIL break_perr: got %b expected 0", perr_log[base]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL break_busy_held: got %b expected 1", busy); end
      bit_time(1'b1); bit_time(1'b1);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL break_release: got %b expected 0", busy); end
      send_frame(8'h55, 1'b1, 1'b1);
      bit_time(1'b1); bit_time(1'b1);
      checks++; if (valid_cnt - base !== 2) begin errors++; $display("FAIL break_next_count: got %0d expected 2", valid_cnt - base); end
      checks++; if (data_log[base+1] !== 8'h55) begin errors++; $display("FAIL break_next_data: got %h expected 55", data_log[base+1]); end
      checks++; if ({perr_log[base+1], ferr_log[base+1]} !== 2'b00) begin errors++; $display("FAIL break_next_flags: got %b expected 00", {perr_log[base+1], ferr_log[base+1]}); end
   endtask

   task automatic test_back_to_back();
      int base = valid_cnt;
      int dc   = double_cnt;
      send_frame(8'h00, 1'b1, 1'b1);
      send_frame(8'hFF, 1'b1, 1'b1);
      bit_time(1'b1); bit_time(1'b1);
      checks++; if (valid_cnt - base !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", valid_cnt - base); end
      checks++; if (data_log[base] !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h expected 00", data_log[base]); end
      checks++; if (data_log[base+1] !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h expected ff", data_log[base+1]); end
      checks++; if ({perr_log[base], ferr_log[base], perr_log[base+1], ferr_log[base+1]} !== 4'b0000) begin
         errors++; $display("FAIL b2b_flags: got %b expected 0000", {perr_log[base], ferr_log[base], perr_log[base+1], ferr_log[base+1]}); end
      checks++; if (double_cnt !== dc) begin errors++; $display("FAIL b2b_width: got %0d long strobes expected 0", double_cnt - dc); end
   endtask

   task automatic test_reset_mid_frame();
      int base = valid_cnt;
      // 0xC3 LSB first: 1,1,0,0,... ; reset lands mid fourth data bit.
      bit_time(1'b0);
      bit_time(1'b1); bit_time(1'b1); bit_time(1'b0);
      RX = 1'b0;
      repeat (CPB / 2) @(negedge CLOCK_50);
      rst = 1'b1;
      @(negedge CLOCK_50);
      rst = 1'b0;
      RX  = 1'b1;
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
      checks++; if ({rx_valid, parity_err, frame_err} !== 3'b000) begin errors++; $display("FAIL rstmid_flags: got %b expected 000", {rx_valid, parity_err, frame_err}); end
      bit_time(1'b1); bit_time(1'b1); bit_time(1'b1);
      checks++; if (valid_cnt - base !== 0) begin errors++; $display("FAIL rstmid_no_valid: got %0d expected 0", valid_cnt - base); end
      send_frame(8'h81, 1'b1, 1'b1);
      bit_time(1'b1); bit_time(1'b1);
      checks++; if (valid_cnt - base !== 1) begin errors++; $display("FAIL rstmid_next_count: got %0d expected 1", valid_cnt - base); end
      checks++; if (data_log[base] !== 8'h81) begin errors++; $display("FAIL rstmid_next_data: got %h expected 81", data_log[base]); end
      checks++; if ({perr_log[base], ferr_log[base]} !== 2'b00) begin errors++; $display("FAIL rstmid_next_flags: got %b expected 00", {perr_log[base], ferr_log[base]}); end
   endtask

   initial begin
      @(negedge CLOCK_50);
      test_reset();
      test_good_frame();
      test_parity_error();
      test_glitch();
      test_break();
      test_back_to_back();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
